// File: rtl/dcache_if.sv
// Processor-side and memory-side handshake bundle for the data cache.
// slave is the cache's view; master is the environment's view (processor plus memory).
interface dcache_if;
   logic        read;
   logic        write;
   logic [7:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic        busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   modport slave (
      input  read, write, address, writedata, mem_readdata, mem_busywait,
      output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
   );

   modport master (
      output read, write, address, writedata, mem_readdata, mem_busywait,
      input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
   );
endinterface

// File: rtl/dcache.sv
// Direct-mapped write-back data cache: 8 blocks x 4 bytes, 8-bit processor port,
// 32-bit block memory port. Hits are zero-stall; misses write back a dirty victim, then fetch.
module dcache (
   input logic     clk,
   input logic     rst,
   dcache_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WRITEBACK = 2'b01,
      FETCH     = 2'b10
   } state_t;

   state_t      state, state_next;
   logic        entry;
   logic [7:0]  valid, dirty;
   logic [2:0]  tags   [8];
   logic [31:0] blocks [8];

   logic [2:0]  tag_in, idx;
   logic [1:0]  off;
   logic        req, hit, mem_done, fill, write_hit;

   always_comb begin
      tag_in    = bus.address[7:5];
      idx       = bus.address[4:2];
      off       = bus.address[1:0];
      req       = bus.read | bus.write;
      hit       = valid[idx] & (tags[idx] == tag_in);
      // memory raises its busy flag combinationally from our request, so the entry edge is ignored
      mem_done  = ~entry & ~bus.mem_busywait;
      fill      = (state == FETCH) & mem_done;
      write_hit = (state == IDLE) & bus.write & hit;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req && !hit)
               state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
         end
         WRITEBACK: begin
            if (mem_done)
               state_next = FETCH;
         end
         FETCH: begin
            if (mem_done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         entry <= 1'b0;
      end else begin
         state <= state_next;
         entry <= (state_next != state);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (fill) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (write_hit) begin
         dirty[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         blocks[idx] <= bus.mem_readdata;
         tags[idx]   <= tag_in;
      end else if (write_hit) begin
         blocks[idx][{off, 3'b000} +: 8] <= bus.writedata;
      end
   end

   // memory strobes decode straight from the state register, so reset drops them at once
   always_comb begin
      bus.busywait      = ~rst & req & ~((state == IDLE) & hit);
      bus.readdata      = blocks[idx][{off, 3'b000} +: 8];
      bus.mem_read      = (state == FETCH);
      bus.mem_write     = (state == WRITEBACK);
      bus.mem_address   = (state == WRITEBACK) ? {tags[idx], idx} : bus.address[7:2];
      bus.mem_writedata = blocks[idx];
   end
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: a transaction-level cache/memory model predicts the
// per-cycle processor and memory-side outputs, which a negedge process compares.
module tb_dcache;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_if bus();
   dcache u_dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   logic [31:0] mem_arr [64];
   int unsigned lat_w = 1, lat_f = 1;
   logic [1:0]  kind, kind_q;
   int unsigned cnt;

   assign kind = {bus.mem_read, bus.mem_write};

   always_comb begin
      bus.mem_readdata = mem_arr[bus.mem_address];
      if (kind == 2'b00)
         bus.mem_busywait = 1'b0;
      else if (kind != kind_q)
         bus.mem_busywait = 1'b1;
      else
         bus.mem_busywait = (cnt < (bus.mem_read ? lat_f : lat_w));
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         kind_q <= 2'b00;
         cnt    <= 0;
      end else begin
         kind_q <= kind;
         if (kind == 2'b00)      cnt <= 0;
         else if (kind != kind_q) cnt <= 1;
         else                    cnt <= cnt + 1;
         if (bus.mem_write && !bus.mem_busywait)
            mem_arr[bus.mem_address] <= bus.mem_writedata;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem   [64];
   bit          ref_valid [8];
   bit          ref_dirty [8];
   logic [2:0]  ref_tag   [8];
   logic [31:0] ref_data  [8];

   typedef struct {
      bit          bw;
      bit          mr;
      bit          mw;
      bit          chk_ma;
      logic [5:0]  ma;
      bit          chk_wd;
      logic [31:0] wd;
      bit          chk_rd;
      logic [7:0]  rd;
   } exp_t;
   exp_t expq[$];
   bit chk_en = 1'b0;

   task automatic push_rec(input bit bw, input bit mr, input bit mw, input bit cma,
                           input logic [5:0] ma, input bit cwd, input logic [31:0] wd,
                           input bit crd, input logic [7:0] rd);
      exp_t e;
      e.bw = bw; e.mr = mr; e.mw = mw; e.chk_ma = cma; e.ma = ma;
      e.chk_wd = cwd; e.wd = wd; e.chk_rd = crd; e.rd = rd;
      expq.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         ref_valid[i] = 1'b0;
         ref_dirty[i] = 1'b0;
      end
   endtask

   // Expected cycle-by-cycle behaviour of one processor request; returns its length in cycles.
   task automatic model_xact(input bit r, input bit w, input logic [7:0] a, input logic [7:0] wd,
                             input int unsigned lw, input int unsigned lf, output int n);
      logic [2:0] i, t;
      int         o;
      i = a[4:2]; t = a[7:5]; o = int'(a[1:0]);
      n = 1;
      if (!(ref_valid[i] && ref_tag[i] == t)) begin
         push_rec(1, 0, 0, 0, '0, 0, '0, 0, '0);
         n++;
         if (ref_valid[i] && ref_dirty[i]) begin
            for (int k = 0; k <= int'(lw); k++)
               push_rec(1, 0, 1, 1, {ref_tag[i], i}, 1, ref_data[i], 0, '0);
            n += int'(lw) + 1;
            ref_mem[{ref_tag[i], i}] = ref_data[i];
         end
         for (int k = 0; k <= int'(lf); k++)
            push_rec(1, 1, 0, 1, a[7:2], 0, '0, 0, '0);
         n += int'(lf) + 1;
         ref_data[i]  = ref_mem[a[7:2]];
         ref_tag[i]   = t;
         ref_valid[i] = 1'b1;
         ref_dirty[i] = 1'b0;
      end
      if (w) begin
         ref_data[i][o*8 +: 8] = wd;
         ref_dirty[i] = 1'b1;
         push_rec(0, 0, 0, 0, '0, 0, '0, 0, '0);
      end else begin
         push_rec(0, 0, 0, 0, '0, 0, '0, r, ref_data[i][o*8 +: 8]);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      exp_t e;
      if (chk_en && expq.size() > 0) begin
         e = expq.pop_front();
         chk("busywait", bus.busywait, e.bw);
         chk("mem_read", bus.mem_read, e.mr);
         chk("mem_write", bus.mem_write, e.mw);
         if (e.chk_ma) chk("mem_address", bus.mem_address, e.ma);
         if (e.chk_wd) chk("mem_writedata", bus.mem_writedata, e.wd);
         if (e.chk_rd) chk("readdata", bus.readdata, e.rd);
      end
   end

   // ---------------- driver ----------------
   task automatic xact(input bit r, input bit w, input logic [7:0] a, input logic [7:0] wd,
                       input int unsigned lw, input int unsigned lf,
                       output logic [7:0] rdata, output int stalls);
      int n;
      model_xact(r, w, a, wd, lw, lf, n);
      lat_w = lw;
      lat_f = lf;
      bus.read = r; bus.write = w; bus.address = a; bus.writedata = wd;
      stalls = 0;
      rdata  = 'x;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (bus.busywait) stalls++;
         rdata = bus.readdata;
         @(posedge clk);
         #1;
      end
      bus.read = 1'b0;
      bus.write = 1'b0;
   endtask

   task automatic idle_cycle();
      push_rec(0, 0, 0, 0, '0, 0, '0, 0, '0);
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rd;
   int         st;
   int         sel;
   bit         r, w;
   logic [7:0] addr, wdat;
   int unsigned lat;

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem_arr[i] = $urandom;
         ref_mem[i] = mem_arr[i];
      end
      mem_arr[9]     = 32'hDDCCBBAA; ref_mem[9]     = 32'hDDCCBBAA;
      mem_arr[6'h11] = 32'h44332211; ref_mem[6'h11] = 32'h44332211;
      model_reset();

      // reset state, with a request pending
      rst = 1'b1;
      bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'h25; bus.writedata = '0;
      repeat (3) @(negedge clk);
      chk("reset_busywait", bus.busywait, 1'b0);
      chk("reset_mem_read", bus.mem_read, 1'b0);
      chk("reset_mem_write", bus.mem_write, 1'b0);
      bus.read = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      idle_cycle();

      // clean fill, read hit, write hit, dirty eviction, clean eviction
      xact(1, 0, 8'h25, 8'h00, 1, 3, rd, st);
      chk("lit_rd25", rd, 8'hBB);
      chk("lit_stall_clean", st, 5);
      xact(1, 0, 8'h24, 8'h00, 1, 1, rd, st);
      chk("lit_rd24", rd, 8'hAA);
      chk("lit_stall_hit", st, 0);
      xact(0, 1, 8'h26, 8'h5A, 1, 1, rd, st);
      chk("lit_stall_whit", st, 0);
      xact(1, 0, 8'h26, 8'h00, 1, 1, rd, st);
      chk("lit_rd26", rd, 8'h5A);
      xact(1, 0, 8'h45, 8'h00, 2, 2, rd, st);
      chk("lit_wb_block", mem_arr[9], 32'hDD5ABBAA);
      chk("lit_rd45", rd, 8'h22);
      chk("lit_stall_dirty", st, 7);
      xact(1, 0, 8'h65, 8'h00, 1, 1, rd, st);
      chk("lit_stall_clean_evict", st, 3);
      idle_cycle();

      // reset in the middle of a fetch
      chk_en = 1'b0;
      lat_f = 20;
      bus.read = 1'b1; bus.address = 8'h85;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_rst_mem_read", bus.mem_read, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_fetch_mem_read", bus.mem_read, 1'b0);
      chk("rst_fetch_mem_write", bus.mem_write, 1'b0);
      chk("rst_fetch_busywait", bus.busywait, 1'b0);
      @(negedge clk);
      bus.read = 1'b0;
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      chk_en = 1'b1;
      xact(1, 0, 8'h85, 8'h00, 1, 2, rd, st);
      chk("lit_stall_after_rst", st, 4);

      // latency sweep on index 7: first a clean fill, then two dirty evictions
      for (int k = 0; k < 3; k++) begin
         lat  = (k == 0) ? 1 : ((k == 1) ? 5 : 20);
         addr = {3'(k), 3'd7, 2'd0};
         xact(0, 1, addr, 8'hC0 + 8'(k), lat, lat, rd, st);
         chk("sweep_stall", st, (k == 0) ? int'(lat) + 2 : 2 * int'(lat) + 3);
      end

      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         sel  = $urandom_range(0, 9);
         r    = (sel < 5) || (sel == 9);
         w    = (sel >= 5);
         addr = 8'($urandom);
         wdat = 8'($urandom);
         xact(r, w, addr, wdat, $urandom_range(1, 4), $urandom_range(1, 4), rd, st);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end

      idle_cycle();
      chk("queue_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
